// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes and FSM states.
package mdu_iter_pkg;

    localparam logic [3:0] MDUOP_MUL    = 4'd0;
    localparam logic [3:0] MDUOP_MULH   = 4'd1;
    localparam logic [3:0] MDUOP_MULHSU = 4'd2;
    localparam logic [3:0] MDUOP_MULHU  = 4'd3;
    localparam logic [3:0] MDUOP_DIV    = 4'd4;
    localparam logic [3:0] MDUOP_DIVU   = 4'd5;
    localparam logic [3:0] MDUOP_REM    = 4'd6;
    localparam logic [3:0] MDUOP_REMU   = 4'd7;
    localparam logic [3:0] MDUOP_MULW   = 4'd8;
    localparam logic [3:0] MDUOP_DIVW   = 4'd9;
    localparam logic [3:0] MDUOP_DIVUW  = 4'd10;
    localparam logic [3:0] MDUOP_REMW   = 4'd11;
    localparam logic [3:0] MDUOP_REMUW  = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } mdu_state_t;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module mdu_divstep #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem_i,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_o,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // Partial remainder is always below the divisor, so the top bit of the trial is a clean borrow flag.
    assign shifted = {rem_i, dividend_bit};
    assign trial   = shifted - {1'b0, divisor};
    assign q_bit   = ~trial[W];
    assign rem_o   = q_bit ? trial[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: 1 bit per cycle on operand magnitudes, sign fix-up on exit.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int MDUOP_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MDUOP_LEN-1:0] mdu_op_i,
    input  logic [XLEN-1:0]      alu_a_i,
    input  logic [XLEN-1:0]      alu_b_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      mdu_out,
    output logic                 busy
);

    localparam int CW = $clog2(XLEN) + 1;

    function automatic logic is_word(input logic [MDUOP_LEN-1:0] op);
        return op inside {MDUOP_MULW, MDUOP_DIVW, MDUOP_DIVUW, MDUOP_REMW, MDUOP_REMUW};
    endfunction
    function automatic logic is_signed_a(input logic [MDUOP_LEN-1:0] op);
        return op inside {MDUOP_MUL, MDUOP_MULH, MDUOP_MULHSU, MDUOP_DIV, MDUOP_REM,
                          MDUOP_MULW, MDUOP_DIVW, MDUOP_REMW};
    endfunction
    function automatic logic is_signed_b(input logic [MDUOP_LEN-1:0] op);
        return op inside {MDUOP_MUL, MDUOP_MULH, MDUOP_DIV, MDUOP_REM,
                          MDUOP_MULW, MDUOP_DIVW, MDUOP_REMW};
    endfunction
    function automatic logic is_div(input logic [MDUOP_LEN-1:0] op);
        return op inside {MDUOP_DIV, MDUOP_DIVU, MDUOP_DIVW, MDUOP_DIVUW};
    endfunction
    function automatic logic is_rem(input logic [MDUOP_LEN-1:0] op);
        return op inside {MDUOP_REM, MDUOP_REMU, MDUOP_REMW, MDUOP_REMUW};
    endfunction
    function automatic logic is_high(input logic [MDUOP_LEN-1:0] op);
        return op inside {MDUOP_MULH, MDUOP_MULHSU, MDUOP_MULHU};
    endfunction
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    mdu_state_t            state;
    logic [MDUOP_LEN-1:0]  op_q;
    logic                  word_q;
    logic                  divide_q;
    logic                  neg_res_q;
    logic                  neg_rem_q;
    logic [CW-1:0]         cnt;
    logic [2*XLEN-1:0]     acc;
    logic [2*XLEN-1:0]     mcand;
    logic [XLEN-1:0]       opnd_b;
    logic [XLEN-1:0]       quo;
    logic [XLEN-1:0]       rem;

    logic                  in_word, in_sa, in_sb, in_divide, fast;
    logic [XLEN-1:0]       a_eff, b_eff, a_mag, b_mag, min_neg, fast_res;

    // Operand preparation and fast-path detection for the op presented at the input.
    always_comb begin
        in_word   = is_word(mdu_op_i);
        in_divide = is_div(mdu_op_i) | is_rem(mdu_op_i);
        a_eff     = alu_a_i;
        b_eff     = alu_b_i;
        if (in_word) begin
            a_eff = is_signed_a(mdu_op_i) ? sext32(alu_a_i[31:0]) : XLEN'(alu_a_i[31:0]);
            b_eff = is_signed_b(mdu_op_i) ? sext32(alu_b_i[31:0]) : XLEN'(alu_b_i[31:0]);
        end
        in_sa   = is_signed_a(mdu_op_i) & a_eff[XLEN-1];
        in_sb   = is_signed_b(mdu_op_i) & b_eff[XLEN-1];
        a_mag   = in_sa ? -a_eff : a_eff;
        b_mag   = in_sb ? -b_eff : b_eff;
        min_neg = in_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        fast    = 1'b0;
        fast_res = '0;
        if (in_divide && b_eff == '0) begin
            fast     = 1'b1;
            fast_res = is_rem(mdu_op_i) ? a_eff : '1;
        end else if (in_divide && is_signed_a(mdu_op_i) && a_eff == min_neg && (&b_eff)) begin
            fast     = 1'b1;
            fast_res = is_rem(mdu_op_i) ? '0 : a_eff;
        end
        if (in_word) fast_res = sext32(fast_res[31:0]);
    end

    logic [2*XLEN-1:0] acc_nxt, mcand_nxt, prod_s;
    logic [XLEN-1:0]   quo_nxt, rem_nxt, div_rem, q_s, r_s, raw, calc_res;
    logic              div_qbit;
    logic [CW-1:0]     last_cnt;

    mdu_divstep #(.W(XLEN)) u_divstep (
        .rem_i        (rem),
        .dividend_bit (quo[XLEN-1]),
        .divisor      (opnd_b),
        .rem_o        (div_rem),
        .q_bit        (div_qbit)
    );

    // One iteration step plus the signed result that would be produced if this is the last step.
    always_comb begin
        acc_nxt   = (quo[0] && !divide_q) ? acc + mcand : acc;
        mcand_nxt = mcand << 1;
        quo_nxt   = divide_q ? {quo[XLEN-2:0], div_qbit} : quo >> 1;
        rem_nxt   = divide_q ? div_rem : rem;
        prod_s    = neg_res_q ? -acc_nxt : acc_nxt;
        q_s       = neg_res_q ? -quo_nxt : quo_nxt;
        r_s       = neg_rem_q ? -rem_nxt : rem_nxt;
        if (is_high(op_q))     raw = prod_s[2*XLEN-1:XLEN];
        else if (is_div(op_q)) raw = q_s;
        else if (is_rem(op_q)) raw = r_s;
        else                   raw = prod_s[XLEN-1:0];
        calc_res = word_q ? sext32(raw[31:0]) : raw;
        last_cnt = word_q ? CW'(31) : CW'(XLEN-1);
    end

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Flush outranks everything except reset; it drops any result but leaves mdu_out untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            mdu_out   <= '0;
            op_q      <= '0;
            word_q    <= 1'b0;
            divide_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            opnd_b    <= '0;
            quo       <= '0;
            rem       <= '0;
        end else if (flush_i) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q      <= mdu_op_i;
                        word_q    <= in_word;
                        divide_q  <= in_divide;
                        neg_res_q <= in_sa ^ in_sb;
                        neg_rem_q <= in_sa;
                        cnt       <= '0;
                        acc       <= '0;
                        rem       <= '0;
                        mcand     <= {{XLEN{1'b0}}, a_mag};
                        opnd_b    <= b_mag;
                        // Divide consumes the dividend MSB-first, so W dividends are parked at the top.
                        if (in_divide)
                            quo <= in_word ? (a_mag << (XLEN-32)) : a_mag;
                        else
                            quo <= b_mag;
                        if (fast) begin
                            mdu_out   <= fast_res;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc   <= acc_nxt;
                    mcand <= mcand_nxt;
                    quo   <= quo_nxt;
                    rem   <= rem_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == last_cnt) begin
                        mdu_out   <= calc_res;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: latency, results, fast paths, backpressure, flush and reset.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  mdu_op_i = '0;
    logic [63:0] alu_a_i = '0;
    logic [63:0] alu_b_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] mdu_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mdu_iter #(.XLEN(64), .MDUOP_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mdu_op_i  (mdu_op_i),
        .alu_a_i   (alu_a_i),
        .alu_b_i   (alu_b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mdu_out   (mdu_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an op for one accepting cycle T; returns at T+1.
    task automatic issue_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        mdu_op_i = op;
        alu_a_i  = a;
        alu_b_i  = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Latency counted from the accept cycle T; 200 means the bound expired.
    task automatic wait_result(output int lat, output bit saw_ready);
        lat = 1;
        saw_ready = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) saw_ready = 1'b1;
            step();
            lat++;
        end
        if (in_ready) saw_ready = 1'b1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        if (mdu_out !== 64'h0) begin errors++; $display("[TB] FAIL reset_mdu_out got %h want 0", mdu_out); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_mul();
        int lat;
        bit rdy;
        issue_op(MDUOP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
        wait_result(lat, rdy);
        checks += 3;
        if (lat != 65) begin errors++; $display("[TB] FAIL mul_latency got %0d want 65", lat); end
        if (rdy) begin errors++; $display("[TB] FAIL mul_in_ready got high while busy want low"); end
        if (mdu_out !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("[TB] FAIL mul_result got %h want fffffffffffffff1", mdu_out); end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL mul_release got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_mulh();
        logic [3:0]  ops [3] = '{MDUOP_MULH, MDUOP_MULHU, MDUOP_MULHSU};
        logic [63:0] as  [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] bs  [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
        logic [63:0] exp [3] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF};
        int lat;
        bit rdy;
        for (int i = 0; i < 3; i++) begin
            issue_op(ops[i], as[i], bs[i]);
            wait_result(lat, rdy);
            checks += 2;
            if (lat != 65) begin errors++; $display("[TB] FAIL mulh%0d_latency got %0d want 65", i, lat); end
            if (mdu_out !== exp[i]) begin errors++; $display("[TB] FAIL mulh%0d_result got %h want %h", i, mdu_out, exp[i]); end
            handshake();
        end
    endtask

    task automatic test_div_fast();
        logic [3:0]  ops [4] = '{MDUOP_DIV, MDUOP_REM, MDUOP_DIV, MDUOP_REM};
        logic [63:0] as  [4] = '{64'd20, 64'd20, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        logic [63:0] bs  [4] = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] exp [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd20, 64'h8000_0000_0000_0000, 64'd0};
        int lat;
        bit rdy;
        for (int i = 0; i < 4; i++) begin
            issue_op(ops[i], as[i], bs[i]);
            wait_result(lat, rdy);
            checks += 2;
            if (lat != 1) begin errors++; $display("[TB] FAIL fast%0d_latency got %0d want 1", i, lat); end
            if (mdu_out !== exp[i]) begin errors++; $display("[TB] FAIL fast%0d_result got %h want %h", i, mdu_out, exp[i]); end
            handshake();
        end
    endtask

    task automatic test_word();
        logic [3:0]  ops [3] = '{MDUOP_DIVW, MDUOP_REMW, MDUOP_DIVUW};
        logic [63:0] as  [3] = '{64'h0000_0000_FFFF_FFF9, 64'h0000_0000_FFFF_FFF9, 64'h0000_0001_8000_0000};
        logic [63:0] bs  [3] = '{64'd2, 64'd2, 64'd1};
        logic [63:0] exp [3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
        int lat;
        bit rdy;
        for (int i = 0; i < 3; i++) begin
            issue_op(ops[i], as[i], bs[i]);
            wait_result(lat, rdy);
            checks += 2;
            if (lat != 33) begin errors++; $display("[TB] FAIL word%0d_latency got %0d want 33", i, lat); end
            if (mdu_out !== exp[i]) begin errors++; $display("[TB] FAIL word%0d_result got %h want %h", i, mdu_out, exp[i]); end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit rdy;
        issue_op(MDUOP_DIVU, 64'd100, 64'd7);
        wait_result(lat, rdy);
        checks++;
        if (lat != 65) begin errors++; $display("[TB] FAIL bp_latency got %0d want 65", lat); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || mdu_out !== 64'd14) begin
                errors++; $display("[TB] FAIL bp_hold%0d got valid=%b out=%h want valid=1 out=e", i, out_valid, mdu_out);
            end
            step();
        end
        handshake();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_after got %b want 1", in_ready); end
        issue_op(MDUOP_REMU, 64'd100, 64'd7);
        wait_result(lat, rdy);
        checks++;
        if (mdu_out !== 64'd2) begin errors++; $display("[TB] FAIL bp_remu got %h want 2", mdu_out); end
        handshake();
    endtask

    // Aborts a MUL at T+10 with a competing request; use_rst selects reset instead of flush.
    task automatic test_abort(input bit use_rst);
        int lat;
        bit rdy;
        bit seen = 1'b0;
        issue_op(MDUOP_MUL, 64'd3, 64'd5);
        repeat (9) step();
        if (use_rst) rst = 1'b1; else flush_i = 1'b1;
        mdu_op_i = MDUOP_DIVU;
        alu_a_i  = 64'd100;
        alu_b_i  = 64'd7;
        in_valid = 1'b1;
        step();
        rst = 1'b0;
        flush_i = 1'b0;
        in_valid = 1'b0;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort%0d_busy got %b want 0", use_rst, busy); end
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort%0d_in_ready got %b want 1", use_rst, in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort%0d_out_valid got %b want 0", use_rst, out_valid); end
        if (use_rst) begin
            checks++;
            if (mdu_out !== 64'h0) begin errors++; $display("[TB] FAIL abort_rst_mdu_out got %h want 0", mdu_out); end
        end
        for (int i = 0; i < 80; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin errors++; $display("[TB] FAIL abort%0d_no_result got out_valid high want none", use_rst); end
        if (!use_rst) begin
            issue_op(MDUOP_DIV, 64'd7, 64'd2);
            wait_result(lat, rdy);
            checks += 2;
            if (lat != 65) begin errors++; $display("[TB] FAIL abort_div_latency got %0d want 65", lat); end
            if (mdu_out !== 64'd3) begin errors++; $display("[TB] FAIL abort_div_result got %h want 3", mdu_out); end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div_fast();
        test_word();
        test_backpressure();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
